vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- CLK_DIV, 2, CLK cycles per pixel (allowed range 1..4)
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_VIS, 640, horizontal visible pixels
- H_FP, 16, horizontal front porch in pixels
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- V_VIS, 480, vertical visible lines
- V_FP, 10, vertical front porch in lines
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, in, 1, system clock (50 MHz)
- RST, in, 1, synchronous active-high reset
- HCOUNT, out, 10, pixel index in the current line
- VCOUNT, out, 10, line index in the current frame; feeds the vertical colour-band FSM address input
- HSYNC, out, 1, horizontal sync, active low
- VSYNC, out, 1, vertical sync, active low
- ACTIVE, out, 1, high when the current pixel is visible
- PIX_EN, out, 1, high when the counters advance at the next CLK edge
- FRAME_START, out, 1, one-CLK pulse when the counters wrap to (0,0)

Function
REQ-004 Line timing SHALL place sync first: HCOUNT 0..H_SYNC-1 is sync, then back porch, then visible, then front porch; H_TOTAL = sum of the four H parameters (800).
REQ-005 Frame timing SHALL use the same order: VCOUNT 0..1 is sync, 2..34 is back porch, 35..514 is visible, and 515..524 is front porch; V_TOTAL = 525.
REQ-006 An internal divider SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-007 PIX_EN SHALL be a decode of divider == CLK_DIV-1; when CLK_DIV=1, PIX_EN SHALL be constantly high.
REQ-008 HCOUNT SHALL increment only on edges where PIX_EN=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-009 VCOUNT SHALL increment only on edges where PIX_EN=1 and HCOUNT=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0.
REQ-010 HSYNC, VSYNC and ACTIVE SHALL be registered, computed from the next counter values, and therefore always consistent with the current HCOUNT/VCOUNT with zero lag.
REQ-011 HSYNC SHALL be 0 iff HCOUNT < H_SYNC.
REQ-012 VSYNC SHALL be 0 iff VCOUNT < V_SYNC.
REQ-013 ACTIVE SHALL be 1 iff both counters are inside their visible windows (H 144..783, V 35..514).
REQ-014 FRAME_START SHALL be high for exactly the one CLK cycle after the edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-015 FRAME_START SHALL NOT assert on reset exit.
REQ-016 Counter arithmetic SHALL be 10-bit unsigned; the counters SHALL never exceed TOTAL-1.
REQ-017 Elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 1024, or if CLK_DIV is out of range.

Reset
REQ-018 While RST=1 on a CLK edge, the block SHALL load: divider=0, HCOUNT=0, VCOUNT=0, HSYNC=0, VSYNC=0, ACTIVE=0, FRAME_START=0.
REQ-019 Reset SHALL take priority over counting at any point in the frame.
REQ-020 After reset is released, the first counter advance SHALL occur CLK_DIV edges later.

Structure
REQ-021 The timing defaults, derived totals and window bounds SHALL live in a shared package, vga_timing_pkg, so that colour-band stages use the same constants.
REQ-022 The divider SHALL be a single sub-module, pixel_tick_gen (inputs CLK, RST; output PIX_EN).

Verification
REQ-023 Reset: hold RST for 3 CLKs -> HCOUNT=0, VCOUNT=0, HSYNC=0, VSYNC=0, ACTIVE=0; PIX_EN pattern after release is 0,1,0,1 with CLK_DIV=2.
REQ-024 Line wrap: run to HCOUNT=799 -> on the next PIX_EN edge HCOUNT=0 and VCOUNT increments by 1; HSYNC is low for exactly 192 CLKs per line.
REQ-025 Frame wrap: run to (799,524) -> counters go to (0,0), FRAME_START is high for 1 CLK, and VSYNC is low for 2×800 pixels.
REQ-026 Active window: ACTIVE first rises at (144,35), last pixel is (783,514), and the total active pixels per frame is 307200.
REQ-027 Mid-frame reset: assert RST at (400,300) for 1 CLK -> next cycle shows (0,0) with no FRAME_START, and a normal frame follows.
REQ-028 CLK_DIV=1: PIX_EN is constantly 1, and one frame takes exactly 420000 CLKs.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and window helpers, so the timing generator and
// any downstream colour-band stages agree on the same line/frame geometry.
package vga_timing_pkg;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned CNT_LIMIT = 1 << CNT_W;

  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_H_VIS   = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam int unsigned DEF_V_VIS   = 480;
  localparam int unsigned DEF_V_FP    = 10;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_VIS + DEF_H_FP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_VIS + DEF_V_FP;
  localparam int unsigned DEF_H_ACT_LO = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_H_ACT_HI = DEF_H_ACT_LO + DEF_H_VIS - 1;
  localparam int unsigned DEF_V_ACT_LO = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_V_ACT_HI = DEF_V_ACT_LO + DEF_V_VIS - 1;

  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so bounds equal to CNT_LIMIT compare correctly.
  typedef logic [CNT_W:0]   cnt_ext_t;

  function automatic logic cnt_below(cnt_t c, int unsigned n);
    return cnt_ext_t'(c) < cnt_ext_t'(n);
  endfunction

  function automatic logic in_window(cnt_t c, int unsigned lo, int unsigned len);
    return (cnt_ext_t'(c) >= cnt_ext_t'(lo)) && (cnt_ext_t'(c) < cnt_ext_t'(lo + len));
  endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: divides CLK by CLK_DIV, PIX_EN high on the last phase.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic PIX_EN
);
  if (CLK_DIV == 1) begin : g_div1
    assign PIX_EN = 1'b1;
  end else begin : g_div
    logic [1:0] div_q, div_d;

    assign PIX_EN = (div_q == 2'(CLK_DIV - 1));

    always_comb begin
      div_d = div_q + 2'd1;
      if (PIX_EN) div_d = 2'd0;
    end

    always_ff @(posedge CLK) begin
      if (RST) div_q <= 2'd0;
      else     div_q <= div_d;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA line/frame counters with registered sync/active flags derived from the
// next counter values, so flags always line up with HCOUNT/VCOUNT.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned H_VIS   = DEF_H_VIS,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter int unsigned V_VIS   = DEF_V_VIS,
  parameter int unsigned V_FP    = DEF_V_FP
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [CNT_W-1:0] HCOUNT,
  output logic [CNT_W-1:0] VCOUNT,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             ACTIVE,
  output logic             PIX_EN,
  output logic             FRAME_START
);
  localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_VIS + V_FP;
  localparam int unsigned H_ACT_LO = H_SYNC + H_BP;
  localparam int unsigned V_ACT_LO = V_SYNC + V_BP;
  localparam cnt_t        H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t        V_LAST   = cnt_t'(V_TOTAL - 1);

  if (H_TOTAL > CNT_LIMIT) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_LIMIT) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be 1..4");
  end

  logic pix_en;
  cnt_t h_q, h_d, v_q, v_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic frame_start_q, frame_start_d;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .PIX_EN (pix_en)
  );

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + cnt_t'(1);
        end
      end else begin
        h_d = h_q + cnt_t'(1);
      end
    end
    hsync_d  = !cnt_below(h_d, H_SYNC);
    vsync_d  = !cnt_below(v_d, V_SYNC);
    active_d = in_window(h_d, H_ACT_LO, H_VIS) && in_window(v_d, V_ACT_LO, V_VIS);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign HCOUNT      = h_q;
  assign VCOUNT      = v_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign ACTIVE      = active_q;
  assign PIX_EN      = pix_en;
  assign FRAME_START = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: four timing generators (default geometry plus three small
// frames at CLK_DIV 1/2/4) checked cycle by cycle against an arithmetic model.
module tb_vga_timing_gen;
  localparam int NI = 4;
  localparam int NCYC = 16000;
  localparam int P_DIV [NI] = '{2, 2, 1, 4};
  localparam int P_HS  [NI] = '{96, 8, 5, 8};
  localparam int P_HB  [NI] = '{48, 4, 3, 4};
  localparam int P_HV  [NI] = '{640, 20, 12, 20};
  localparam int P_HF  [NI] = '{16, 4, 2, 4};
  localparam int P_VS  [NI] = '{2, 2, 1, 2};
  localparam int P_VB  [NI] = '{33, 3, 2, 3};
  localparam int P_VV  [NI] = '{480, 10, 6, 10};
  localparam int P_VF  [NI] = '{10, 2, 2, 2};

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic hs, vs, act, pe, fs, rst;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst;
  logic [9:0] hc [NI];
  logic [9:0] vc [NI];
  logic [NI-1:0] hs, vs, ac, pe, fs;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV(P_DIV[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]), .H_VIS(P_HV[g]), .H_FP(P_HF[g]),
      .V_SYNC(P_VS[g]), .V_BP(P_VB[g]), .V_VIS(P_VV[g]), .V_FP(P_VF[g])
    ) u_dut (
      .CLK(clk), .RST(rst[g]), .HCOUNT(hc[g]), .VCOUNT(vc[g]), .HSYNC(hs[g]),
      .VSYNC(vs[g]), .ACTIVE(ac[g]), .PIX_EN(pe[g]), .FRAME_START(fs[g])
    );
  end

  function automatic int h_tot(int i);
    return P_HS[i] + P_HB[i] + P_HV[i] + P_HF[i];
  endfunction
  function automatic int v_tot(int i);
    return P_VS[i] + P_VB[i] + P_VV[i] + P_VF[i];
  endfunction

  // k = CLK edges since the last reset edge (k=0 is the state right after reset).
  function automatic exp_t model(int i, int k, logic r);
    exp_t e;
    int d, p, fp, h, v, hlo, vlo;
    d   = P_DIV[i];
    p   = k / d;
    fp  = p % (h_tot(i) * v_tot(i));
    h   = fp % h_tot(i);
    v   = fp / h_tot(i);
    hlo = P_HS[i] + P_HB[i];
    vlo = P_VS[i] + P_VB[i];
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = (h >= P_HS[i]);
    e.vs  = (v >= P_VS[i]);
    e.act = (h >= hlo) && (h < hlo + P_HV[i]) && (v >= vlo) && (v < vlo + P_VV[i]);
    e.pe  = ((k % d) == d - 1);
    e.fs  = (p > 0) && (fp == 0) && ((k % d) == 0);
    e.rst = r;
    return e;
  endfunction

  exp_t q [NI][$];
  int n_chk = 0;
  int n_fail = 0;
  int fcyc [NI];
  int fact [NI];
  int fhsl [NI];
  int fvsl [NI];
  bit armed [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      armed[i] = 0; fcyc[i] = 0; fact[i] = 0; fhsl[i] = 0; fvsl[i] = 0;
    end
  end

  // Monitor: pops one expectation per instance per cycle and also checks
  // frame-level totals between consecutive FRAME_START pulses.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (q[i].size() > 0) begin
        e = q[i].pop_front();
        n_chk++;
        if ({hc[i], vc[i], hs[i], vs[i], ac[i], pe[i], fs[i]} !==
            {e.h, e.v, e.hs, e.vs, e.act, e.pe, e.fs}) begin
          n_fail++;
          $display("FAIL cycle inst%0d t=%0t got h=%0d v=%0d hs=%b vs=%b act=%b pe=%b fs=%b need h=%0d v=%0d hs=%b vs=%b act=%b pe=%b fs=%b",
                   i, $time, hc[i], vc[i], hs[i], vs[i], ac[i], pe[i], fs[i],
                   e.h, e.v, e.hs, e.vs, e.act, e.pe, e.fs);
        end
        if (e.rst) armed[i] = 0;
        if (fs[i] === 1'b1) begin
          if (armed[i]) begin
            n_chk++;
            if (fcyc[i] != h_tot(i) * v_tot(i) * P_DIV[i] ||
                fact[i] != P_HV[i] * P_VV[i] ||
                fhsl[i] != P_HS[i] * P_DIV[i] * v_tot(i) ||
                fvsl[i] != P_VS[i] * h_tot(i) * P_DIV[i]) begin
              n_fail++;
              $display("FAIL frame_totals inst%0d got clks=%0d act_pix=%0d hs_low=%0d vs_low=%0d need %0d %0d %0d %0d",
                       i, fcyc[i], fact[i], fhsl[i], fvsl[i],
                       h_tot(i) * v_tot(i) * P_DIV[i], P_HV[i] * P_VV[i],
                       P_HS[i] * P_DIV[i] * v_tot(i), P_VS[i] * h_tot(i) * P_DIV[i]);
            end
          end
          armed[i] = 1;
          fcyc[i] = 0; fact[i] = 0; fhsl[i] = 0; fvsl[i] = 0;
        end
        if (armed[i]) begin
          fcyc[i]++;
          if (ac[i] === 1'b1 && pe[i] === 1'b1) fact[i]++;
          if (hs[i] === 1'b0) fhsl[i]++;
          if (vs[i] === 1'b0) fvsl[i]++;
        end
      end
    end
  end

  // Stimulus: reset held 3 edges, a directed mid-frame reset on inst1, and
  // sparse random resets early on; each edge's expected state is queued.
  initial begin
    int k [NI];
    bit mid_done;
    exp_t cur;
    mid_done = 0;
    for (int i = 0; i < NI; i++) k[i] = 0;
    rst = '1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rst = '0;
      if (cyc < 3) rst = '1;
      for (int i = 0; i < NI; i++)
        if (cyc >= 3 && cyc < 6000 && $urandom_range(0, 2999) == 0) rst[i] = 1'b1;
      cur = model(1, k[1], 1'b0);
      if (!mid_done && cyc >= 3 && k[1] >= h_tot(1) * v_tot(1) * P_DIV[1] &&
          cur.h == 10'd18 && cur.v == 10'd8) begin
        rst[1] = 1'b1;
        mid_done = 1;
      end
      for (int i = 0; i < NI; i++) begin
        k[i] = rst[i] ? 0 : k[i] + 1;
        q[i].push_back(model(i, k[i], rst[i]));
      end
      @(posedge clk);
      #2;
    end
    rst = '0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
